// File: rtl/wordle_pkg.sv
// Shared types and constants for the word-game sequencer: letters, packed words,
// FSM states and display-mode codes.
package wordle_pkg;

   localparam int WORD_LEN = 4;

   typedef logic [4:0] letter_t;
   typedef letter_t [WORD_LEN-1:0] word_t;

   localparam letter_t LETTER_INVALID = 5'd31;
   localparam letter_t LETTER_MAX     = 5'd25;
   localparam word_t   WORD_BLANK     = {WORD_LEN{LETTER_INVALID}};

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      SCORE,
      RESULT,
      WIN,
      LOSE
   } state_t;

   localparam logic [2:0] DISP_BLANK  = 3'd0;
   localparam logic [2:0] DISP_ENTRY  = 3'd1;
   localparam logic [2:0] DISP_RESULT = 3'd2;
   localparam logic [2:0] DISP_WIN    = 3'd3;
   localparam logic [2:0] DISP_LOSE   = 3'd4;

   // The formatter has no scoring view, so SCORE keeps showing the entry screen.
   function automatic logic [2:0] disp_of(input state_t st);
      logic [2:0] d;
      d = DISP_BLANK;
      case (st)
         ENTRY, SCORE: d = DISP_ENTRY;
         RESULT:       d = DISP_RESULT;
         WIN:          d = DISP_WIN;
         LOSE:         d = DISP_LOSE;
         default:      d = DISP_BLANK;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/wordle_game_ctrl_if.sv
// Bus between the switch decoder / display formatter and the game sequencer.
interface wordle_game_ctrl_if;
   logic        enter;
   logic [4:0]  letter_code;
   logic [19:0] secret_word;
   logic [19:0] guess_word;
   logic [1:0]  slot_idx;
   logic [2:0]  disp_mode;
   logic [3:0]  led_correct;
   logic [3:0]  led_present;
   logic [2:0]  guess_count;
   logic        bad_letter;

   modport master (
      output enter, letter_code, secret_word,
      input  guess_word, slot_idx, disp_mode, led_correct, led_present,
             guess_count, bad_letter
   );

   modport slave (
      input  enter, letter_code, secret_word,
      output guess_word, slot_idx, disp_mode, led_correct, led_present,
             guess_count, bad_letter
   );
endinterface

// File: rtl/button_conditioner.sv
// Active-low pushbutton conditioner: 2-FF synchroniser, counting debounce and a
// one-cycle pulse on each accepted press (debounced 1->0).
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DB_W            = 5
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_n,
   output logic press
);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_db;
   logic            r_db_q;
   logic [DB_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_db    <= 1'b1;
         r_db_q  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= btn_n;
         r_sync2 <= r_sync1;
         r_db_q  <= r_db;
         // Any sample agreeing with the accepted level restarts the run.
         if (r_sync2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + DB_W'(1);
         end
      end
   end

   assign press = r_db_q & ~r_db;

endmodule

// File: rtl/wordle_game_ctrl.sv
// Word-game sequencer: letter entry, serial scoring, guess counting, win/lose.
//
//   state  | meaning
//   IDLE   | blank display, waiting for a press to latch the secret and start
//   ENTRY  | each valid press stores a letter in the current slot
//   SCORE  | 4 cycles of per-slot exact match, then one cycle for present flags
//   RESULT | feedback shown, press starts the next guess
//   WIN    | all letters correct, press returns to IDLE
//   LOSE   | guess budget spent, press returns to IDLE
module wordle_game_ctrl
   import wordle_pkg::*;
#(
   parameter int MAX_GUESSES     = 6,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DB_W            = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   wordle_game_ctrl_if.slave bus
);

   localparam logic [2:0] SCORE_PRESENT = 3'(WORD_LEN);
   localparam logic [2:0] GUESS_LIMIT   = 3'(MAX_GUESSES);

   logic w_press;

   state_t     r_state,     w_state_nxt;
   word_t      r_secret,    w_secret_nxt;
   word_t      r_guess,     w_guess_nxt;
   logic [1:0] r_slot_idx,  w_slot_nxt;
   logic [2:0] r_score_idx, w_score_nxt;
   logic [3:0] r_led_c,     w_led_c_nxt;
   logic [3:0] r_led_p,     w_led_p_nxt;
   logic [2:0] r_gcount,    w_gcount_nxt;
   logic       r_bad,       w_bad_nxt;
   logic [3:0] w_present;
   logic [2:0] w_gcount_inc;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
   ) u_btn (
      .clk    (clk),
      .reset_n(reset_n),
      .btn_n  (bus.enter),
      .press  (w_press)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_secret    <= '0;
         r_guess     <= WORD_BLANK;
         r_slot_idx  <= '0;
         r_score_idx <= '0;
         r_led_c     <= '0;
         r_led_p     <= '0;
         r_gcount    <= '0;
         r_bad       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_secret    <= w_secret_nxt;
         r_guess     <= w_guess_nxt;
         r_slot_idx  <= w_slot_nxt;
         r_score_idx <= w_score_nxt;
         r_led_c     <= w_led_c_nxt;
         r_led_p     <= w_led_p_nxt;
         r_gcount    <= w_gcount_nxt;
         r_bad       <= w_bad_nxt;
      end
   end

   // A secret letter already claimed by an exact match cannot also mark present.
   always_comb begin
      w_present = '0;
      for (int i = 0; i < WORD_LEN; i++) begin
         for (int j = 0; j < WORD_LEN; j++) begin
            if (i != j && !r_led_c[i] && !r_led_c[j] && r_secret[j] == r_guess[i]) begin
               w_present[i] = 1'b1;
            end
         end
      end
   end

   assign w_gcount_inc = (r_gcount < GUESS_LIMIT) ? r_gcount + 3'd1 : r_gcount;

   always_comb begin
      w_state_nxt  = r_state;
      w_secret_nxt = r_secret;
      w_guess_nxt  = r_guess;
      w_slot_nxt   = r_slot_idx;
      w_score_nxt  = r_score_idx;
      w_led_c_nxt  = r_led_c;
      w_led_p_nxt  = r_led_p;
      w_gcount_nxt = r_gcount;
      w_bad_nxt    = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (w_press) begin
               w_secret_nxt = bus.secret_word;
               w_guess_nxt  = WORD_BLANK;
               w_led_c_nxt  = '0;
               w_led_p_nxt  = '0;
               w_gcount_nxt = '0;
               w_slot_nxt   = '0;
               w_state_nxt  = ENTRY;
            end
         end
         ENTRY: begin
            if (w_press) begin
               if (bus.letter_code <= LETTER_MAX) begin
                  w_guess_nxt[r_slot_idx] = bus.letter_code;
                  if (r_slot_idx == 2'd3) begin
                     w_score_nxt = '0;
                     w_state_nxt = SCORE;
                  end else begin
                     w_slot_nxt = r_slot_idx + 2'd1;
                  end
               end else begin
                  w_bad_nxt = 1'b1;
               end
            end
         end
         SCORE: begin
            // Presses arriving here, including on the exit cycle, are dropped.
            if (r_score_idx != SCORE_PRESENT) begin
               w_led_c_nxt[r_score_idx[1:0]] =
                  (r_guess[r_score_idx[1:0]] == r_secret[r_score_idx[1:0]]);
               w_score_nxt = r_score_idx + 3'd1;
            end else begin
               w_led_p_nxt = w_present;
               if (&r_led_c) begin
                  w_state_nxt = WIN;
               end else begin
                  w_gcount_nxt = w_gcount_inc;
                  w_state_nxt  = (w_gcount_inc == GUESS_LIMIT) ? LOSE : RESULT;
               end
            end
         end
         RESULT: begin
            if (w_press) begin
               w_guess_nxt = WORD_BLANK;
               w_slot_nxt  = '0;
               w_led_c_nxt = '0;
               w_led_p_nxt = '0;
               w_state_nxt = ENTRY;
            end
         end
         WIN, LOSE: begin
            if (w_press) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.guess_word  = r_guess;
   assign bus.slot_idx    = r_slot_idx;
   assign bus.disp_mode   = disp_of(r_state);
   assign bus.led_correct = r_led_c;
   assign bus.led_present = r_led_p;
   assign bus.guess_count = r_gcount;
   assign bus.bad_letter  = r_bad;

endmodule

// File: tb/tb_wordle_game_ctrl.sv
// Self-checking bench for wordle_game_ctrl: scoring table, timed corner cases and
// randomized games against a word-level reference model.
module tb_wordle_game_ctrl;

   localparam int MAXG = 6;
   localparam int L_A = 0, L_B = 1, L_E = 4, L_I = 8, L_K = 10, L_O = 14, L_S = 18, L_T = 19;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   wordle_game_ctrl_if bus ();

   wordle_game_ctrl #(
      .MAX_GUESSES    (MAXG),
      .DEBOUNCE_CYCLES(16),
      .DB_W           (5)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int bad_seen;
   int press_seen = 0;

   always @(posedge clk) if (dut.u_btn.press) press_seen++;

   typedef struct {
      logic [19:0] secret;
      logic [19:0] guess;
      logic [3:0]  exp_c;
      logic [3:0]  exp_p;
      logic [2:0]  exp_disp;
      logic [2:0]  exp_gc;
   } vec_t;

   vec_t vecs[7];

   function automatic logic [19:0] w4(input int l0, input int l1, input int l2, input int l3);
      return {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
   endfunction

   // Reference scoring: letters of the secret not matched in place form a pool;
   // an unmatched guess letter is present if it appears in that pool.
   function automatic void ref_score(input logic [19:0] s, input logic [19:0] g,
                                     output logic [3:0] c, output logic [3:0] p);
      bit pool[32];
      c = '0;
      p = '0;
      for (int k = 0; k < 32; k++) pool[k] = 1'b0;
      for (int i = 0; i < 4; i++) c[i] = (s[5*i +: 5] == g[5*i +: 5]);
      for (int i = 0; i < 4; i++) if (!c[i]) pool[s[5*i +: 5]] = 1'b1;
      for (int i = 0; i < 4; i++) p[i] = !c[i] && pool[g[5*i +: 5]];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_press(input logic [4:0] code);
      bad_seen = 0;
      bus.letter_code = code;
      bus.enter = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.bad_letter) bad_seen++;
      end
      bus.enter = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.bad_letter) bad_seen++;
      end
   endtask

   task automatic do_reset();
      bus.enter = 1'b1;
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(2);
   endtask

   task automatic enter_word(input logic [19:0] w);
      for (int i = 0; i < 4; i++) do_press(w[5*i +: 5]);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_guess"}, 32'(bus.guess_word), 32'hFFFFF);
      check({tag, "_slot"},  32'(bus.slot_idx), 0);
      check({tag, "_disp"},  32'(bus.disp_mode), 0);
      check({tag, "_ledc"},  32'(bus.led_correct), 0);
      check({tag, "_ledp"},  32'(bus.led_present), 0);
      check({tag, "_gc"},    32'(bus.guess_count), 0);
      check({tag, "_bad"},   32'(bus.bad_letter), 0);
   endtask

   initial begin
      logic [19:0] sec, g, expw;
      logic [3:0]  rc, rp;
      logic [2:0]  exp_disp;
      int          wrong, p0;
      bit          over, win;

      vecs[0] = '{w4(L_B,L_I,L_T,L_S), w4(L_B,L_I,L_T,L_S), 4'hF, 4'h0, 3'd3, 3'd0};
      vecs[1] = '{w4(L_B,L_I,L_T,L_S), w4(L_S,L_T,L_I,L_B), 4'h0, 4'hF, 3'd2, 3'd1};
      vecs[2] = '{w4(L_B,L_I,L_T,L_S), w4(L_A,L_A,L_A,L_A), 4'h0, 4'h0, 3'd2, 3'd1};
      vecs[3] = '{w4(L_B,L_I,L_T,L_S), w4(L_B,L_I,L_S,L_T), 4'h3, 4'hC, 3'd2, 3'd1};
      vecs[4] = '{w4(L_B,L_I,L_T,L_S), w4(L_S,L_S,L_S,L_S), 4'h8, 4'h0, 3'd2, 3'd1};
      vecs[5] = '{w4(L_B,L_O,L_O,L_K), w4(L_O,L_B,L_O,L_E), 4'h4, 4'h3, 3'd2, 3'd1};
      vecs[6] = '{w4(L_A,L_B,L_B,L_A), w4(L_B,L_A,L_A,L_B), 4'h0, 4'hF, 3'd2, 3'd1};

      bus.enter = 1'b1;
      bus.letter_code = '0;
      bus.secret_word = '0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
      check_reset_vals("reset");

      // Short glitch is rejected; a held press is accepted 18 cycles after the edge.
      p0 = press_seen;
      bus.enter = 1'b0;
      tick(5);
      bus.enter = 1'b1;
      tick(30);
      check("glitch_press", 32'(press_seen - p0), 0);
      check("glitch_disp", 32'(bus.disp_mode), 0);
      bus.secret_word = w4(L_B,L_I,L_T,L_S);
      bus.enter = 1'b0;
      tick(17);
      check("press_at_17", 32'(dut.u_btn.press), 0);
      tick(1);
      check("press_at_18", 32'(dut.u_btn.press), 1);
      tick(1);
      check("press_disp", 32'(bus.disp_mode), 1);
      check("press_one_cycle", 32'(dut.u_btn.press), 0);
      tick(1);
      bus.enter = 1'b1;
      tick(20);

      for (int v = 0; v < 7; v++) begin
         do_reset();
         bus.secret_word = vecs[v].secret;
         do_press(5'd0);
         enter_word(vecs[v].guess);
         check($sformatf("vec%0d_guess", v), 32'(bus.guess_word), 32'(vecs[v].guess));
         check($sformatf("vec%0d_ledc", v),  32'(bus.led_correct), 32'(vecs[v].exp_c));
         check($sformatf("vec%0d_ledp", v),  32'(bus.led_present), 32'(vecs[v].exp_p));
         check($sformatf("vec%0d_disp", v),  32'(bus.disp_mode), 32'(vecs[v].exp_disp));
         check($sformatf("vec%0d_gc", v),    32'(bus.guess_count), 32'(vecs[v].exp_gc));
      end

      // Exact five-cycle scoring latency after the last letter is accepted.
      do_reset();
      bus.secret_word = w4(L_B,L_I,L_T,L_S);
      do_press(5'd0);
      do_press(5'(L_B));
      do_press(5'(L_I));
      do_press(5'(L_T));
      bus.letter_code = 5'(L_S);
      bus.enter = 1'b0;
      tick(23);
      check("score_lat_before", 32'(bus.disp_mode), 1);
      tick(1);
      check("score_lat_disp", 32'(bus.disp_mode), 3);
      check("score_lat_ledc", 32'(bus.led_correct), 32'hF);
      check("score_lat_ledp", 32'(bus.led_present), 0);
      check("score_lat_gc", 32'(bus.guess_count), 0);
      bus.enter = 1'b1;
      tick(20);
      do_press(5'd0);
      check("win_to_idle", 32'(bus.disp_mode), 0);

      // Invalid letter in slot 2.
      do_reset();
      bus.secret_word = w4(L_B,L_I,L_T,L_S);
      do_press(5'd0);
      do_press(5'(L_B));
      do_press(5'(L_I));
      check("bad_slot_pre", 32'(bus.slot_idx), 2);
      do_press(5'd31);
      check("bad_pulse_31", 32'(bad_seen), 1);
      check("bad_slot_31", 32'(bus.slot_idx), 2);
      check("bad_letter_slot2", 32'(bus.guess_word[14:10]), 31);
      do_press(5'd26);
      check("bad_pulse_26", 32'(bad_seen), 1);
      do_press(5'(L_T));
      check("bad_then_valid", 32'(bad_seen), 0);
      do_press(5'(L_S));
      check("bad_game_win", 32'(bus.disp_mode), 3);

      // Six wrong guesses; secret changed after latch must be ignored.
      do_reset();
      bus.secret_word = w4(L_B,L_I,L_T,L_S);
      do_press(5'd0);
      bus.secret_word = w4(L_A,L_A,L_A,L_A);
      for (int k = 1; k <= MAXG; k++) begin
         enter_word(w4(L_A,L_A,L_A,L_A));
         check($sformatf("lose_gc%0d", k), 32'(bus.guess_count), 32'(k));
         check($sformatf("lose_disp%0d", k), 32'(bus.disp_mode), (k < MAXG) ? 2 : 4);
         if (k < MAXG) begin
            do_press(5'd0);
            check($sformatf("lose_next%0d", k), 32'(bus.disp_mode), 1);
         end
      end
      do_press(5'd0);
      check("lose_to_idle", 32'(bus.disp_mode), 0);

      // Reset asserted inside the third scoring cycle.
      do_reset();
      bus.secret_word = w4(L_B,L_I,L_T,L_S);
      do_press(5'd0);
      do_press(5'(L_B));
      do_press(5'(L_I));
      do_press(5'(L_T));
      bus.letter_code = 5'(L_S);
      bus.enter = 1'b0;
      tick(21);
      reset_n = 1'b0;
      #1;
      check_reset_vals("rst_score");
      bus.enter = 1'b1;
      tick(3);
      reset_n = 1'b1;
      tick(2);
      do_press(5'd0);
      check("rst_restart_disp", 32'(bus.disp_mode), 1);
      check("rst_restart_gc", 32'(bus.guess_count), 0);
      check("rst_restart_guess", 32'(bus.guess_word), 32'hFFFFF);

      // Randomized games against the reference model.
      do_reset();
      for (int game = 0; game < 3; game++) begin
         for (int i = 0; i < 4; i++) sec[5*i +: 5] = 5'($urandom_range(0, 5));
         bus.secret_word = sec;
         do_press(5'($urandom_range(0, 31)));
         check("rnd_start_disp", 32'(bus.disp_mode), 1);
         check("rnd_start_gc", 32'(bus.guess_count), 0);
         check("rnd_start_bad", 32'(bad_seen), 0);
         bus.secret_word = 20'($urandom);
         wrong = 0;
         over = 1'b0;
         while (!over) begin
            if ($urandom_range(0, 3) == 0) g = sec;
            else for (int i = 0; i < 4; i++) g[5*i +: 5] = 5'($urandom_range(0, 5));
            expw = 20'hFFFFF;
            for (int k = 0; k < 4; k++) begin
               if ($urandom_range(0, 5) == 0) begin
                  do_press(5'($urandom_range(26, 31)));
                  check("rnd_bad_pulse", 32'(bad_seen), 1);
                  check("rnd_bad_slot", 32'(bus.slot_idx), 32'(k));
                  check("rnd_bad_guess", 32'(bus.guess_word), 32'(expw));
               end
               do_press(g[5*k +: 5]);
               expw[5*k +: 5] = g[5*k +: 5];
               check("rnd_entry_bad", 32'(bad_seen), 0);
               check("rnd_entry_guess", 32'(bus.guess_word), 32'(expw));
               if (k < 3) check("rnd_entry_slot", 32'(bus.slot_idx), 32'(k + 1));
            end
            ref_score(sec, g, rc, rp);
            win = (rc == 4'hF);
            if (!win) wrong++;
            exp_disp = win ? 3'd3 : ((wrong == MAXG) ? 3'd4 : 3'd2);
            check("rnd_ledc", 32'(bus.led_correct), 32'(rc));
            check("rnd_ledp", 32'(bus.led_present), 32'(rp));
            check("rnd_disp", 32'(bus.disp_mode), 32'(exp_disp));
            check("rnd_gc", 32'(bus.guess_count), 32'(wrong));
            if (win || wrong == MAXG) begin
               over = 1'b1;
               do_press(5'($urandom_range(0, 31)));
               check("rnd_end_idle", 32'(bus.disp_mode), 0);
               check("rnd_end_bad", 32'(bad_seen), 0);
            end else begin
               do_press(5'($urandom_range(0, 31)));
               check("rnd_next_disp", 32'(bus.disp_mode), 1);
               check("rnd_next_guess", 32'(bus.guess_word), 32'hFFFFF);
               check("rnd_next_led", 32'({bus.led_correct, bus.led_present}), 0);
               check("rnd_next_slot", 32'(bus.slot_idx), 0);
               check("rnd_next_bad", 32'(bad_seen), 0);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
